// File: rtl/lock_timeout_ctrl_if.sv
// rtl/lock_timeout_ctrl_if.sv - start/pause/abort/expire handshake bundle for the lock timeout sequencer
// Ports (master = lock FSM side, slave = lock_timeout_ctrl):
//   start, duration[DUR_W], pause, abort   : master -> slave
//   busy, tick, expired, remaining[DUR_W]  : slave -> master
interface lock_timeout_ctrl_if #(
    parameter int DUR_W = 8
);
    logic             start;
    logic [DUR_W-1:0] duration;
    logic             pause;
    logic             abort;
    logic             busy;
    logic             tick;
    logic             expired;
    logic [DUR_W-1:0] remaining;

    modport master (
        output start, duration, pause, abort,
        input  busy, tick, expired, remaining
    );

    modport slave (
        input  start, duration, pause, abort,
        output busy, tick, expired, remaining
    );
endinterface

// File: rtl/lock_timeout_ctrl.sv
// rtl/lock_timeout_ctrl.sv - 50 ms tick prescaler plus programmable tick down-counter for the lock FSM
// Ports:
//   clk_in : system clock (25 MHz)
//   rst    : asynchronous reset, active-high
//   bus    : lock_timeout_ctrl_if.slave (start/duration/pause/abort in; busy/tick/expired/remaining out)
// Optional feature macro: AUTO_RELOAD_EN (periodic timeout; expiry reloads the latched duration).
// Input priority each cycle: abort > start > pause. All outputs are registered.
module lock_timeout_ctrl #(
    parameter int TICK_DIV = 1250000,
    parameter int PRE_W    = 21,
    parameter int DUR_W    = 8
) (
    input  logic                  clk_in,
    input  logic                  rst,
    lock_timeout_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Wrap point; truncation to PRE_W is intentional, range is checked below.
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

`ifndef SYNTHESIS
    localparam longint PRE_SPAN = longint'(1) << PRE_W;
    if (TICK_DIV < 2 || longint'(TICK_DIV) > PRE_SPAN) begin : g_bad_cfg
        $error("lock_timeout_ctrl: TICK_DIV out of range for PRE_W");
    end
`endif

    state_t             state;
    logic [PRE_W-1:0]   prescaler;
    logic [DUR_W-1:0]   remaining_q;
    logic               busy_q;
    logic               tick_q;
    logic               expired_q;
`ifdef AUTO_RELOAD_EN
    logic [DUR_W-1:0]   reload_q;
`endif

    assign bus.busy      = busy_q;
    assign bus.tick      = tick_q;
    assign bus.expired   = expired_q;
    assign bus.remaining = remaining_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            prescaler   <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            tick_q      <= 1'b0;
            expired_q   <= 1'b0;
`ifdef AUTO_RELOAD_EN
            reload_q    <= '0;
`endif
        end else begin
            tick_q    <= 1'b0;
            expired_q <= 1'b0;

            if (bus.abort) begin
                state       <= IDLE;
                prescaler   <= '0;
                remaining_q <= '0;
                busy_q      <= 1'b0;
            end else if (bus.start) begin
                // Retrigger restarts the phase; a wrap due this cycle is dropped.
                prescaler <= '0;
`ifdef AUTO_RELOAD_EN
                reload_q  <= bus.duration;
`endif
                if (bus.duration != '0) begin
                    remaining_q <= bus.duration;
                    state       <= RUN;
                    busy_q      <= 1'b1;
                end else begin
                    remaining_q <= '0;
                    state       <= DONE;
                    busy_q      <= 1'b0;
                    expired_q   <= 1'b1;
                end
            end else if ((state == RUN || state == PAUSED) && bus.pause) begin
                // Prescaler frozen on the edge that enters PAUSED and while held.
                state <= PAUSED;
            end else if (state == RUN || state == PAUSED) begin
                // Leaving PAUSED counts this edge, so pause stretches timing 1:1.
                state <= RUN;
                if (prescaler == PRE_LAST) begin
                    prescaler <= '0;
                    tick_q    <= 1'b1;
                    if (remaining_q <= DUR_W'(1)) begin
                        expired_q <= 1'b1;
`ifdef AUTO_RELOAD_EN
                        if (reload_q != '0) begin
                            remaining_q <= reload_q;
                        end else begin
                            remaining_q <= '0;
                            state       <= DONE;
                            busy_q      <= 1'b0;
                        end
`else
                        remaining_q <= '0;
                        state       <= DONE;
                        busy_q      <= 1'b0;
`endif
                    end else begin
                        remaining_q <= remaining_q - DUR_W'(1);
                    end
                end else begin
                    prescaler <= prescaler + PRE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lock_timeout_ctrl.sv
// tb/tb_lock_timeout_ctrl.sv - directed self-checking bench for lock_timeout_ctrl (TICK_DIV=4)
module tb_lock_timeout_ctrl;

    localparam int TD    = 4;
    localparam int PRE_W = 3;
    localparam int DUR_W = 8;
`ifdef AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic rst;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    always #5 clk_in = ~clk_in;

    lock_timeout_ctrl_if #(.DUR_W(DUR_W)) bus ();

    lock_timeout_ctrl #(
        .TICK_DIV (TD),
        .PRE_W    (PRE_W),
        .DUR_W    (DUR_W)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus.slave)
    );

    // Outputs are observed 1 time unit after each rising edge.
    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    // Presents start for exactly one edge (edge 0 of a scenario).
    task automatic launch(input logic [DUR_W-1:0] d);
        bus.start    = 1'b1;
        bus.duration = d;
        cyc();
        bus.start    = 1'b0;
        bus.duration = '0;
    endtask

    task automatic clean_up();
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        logic [10:0] got;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.duration = '0;
        bus.pause    = 1'b0;
        bus.abort    = 1'b0;
        cyc();
        cyc();
        got = {bus.busy, bus.tick, bus.expired, bus.remaining};
        chk_cnt++;
        if (got !== 11'h000) $display("FAIL reset_state got=%h exp=%h", got, 11'h000);
        else pass_cnt++;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        logic [10:0] got, exp;
        launch(8'd3);
        got = {bus.busy, bus.tick, bus.expired, bus.remaining};
        chk_cnt++;
        if (got !== {3'b100, 8'd3}) $display("FAIL basic_e0 got=%h exp=%h", got, {3'b100, 8'd3});
        else pass_cnt++;
        for (int e = 1; e <= 15; e++) begin
            cyc();
            if (e < 4)        exp = {3'b100, 8'd3};
            else if (e == 4)  exp = {3'b110, 8'd2};
            else if (e < 8)   exp = {3'b100, 8'd2};
            else if (e == 8)  exp = {3'b110, 8'd1};
            else if (e < 12)  exp = {3'b100, 8'd1};
            else if (e == 12) exp = {AR, 2'b11, (AR ? 8'd3 : 8'd0)};
            else              exp = {AR, 2'b00, (AR ? 8'd3 : 8'd0)};
            got = {bus.busy, bus.tick, bus.expired, bus.remaining};
            chk_cnt++;
            if (got !== exp) $display("FAIL basic e=%0d got=%h exp=%h", e, got, exp);
            else pass_cnt++;
        end
        clean_up();
    endtask

    task automatic test_pause();
        logic [10:0] got, exp;
        launch(8'd2);
        for (int e = 1; e <= 16; e++) begin
            bus.pause = (e >= 2 && e <= 7);
            cyc();
            if (e < 10)       exp = {3'b100, 8'd2};
            else if (e == 10) exp = {3'b110, 8'd1};
            else if (e < 14)  exp = {3'b100, 8'd1};
            else if (e == 14) exp = {AR, 2'b11, (AR ? 8'd2 : 8'd0)};
            else              exp = {AR, 2'b00, (AR ? 8'd2 : 8'd0)};
            got = {bus.busy, bus.tick, bus.expired, bus.remaining};
            chk_cnt++;
            if (got !== exp) $display("FAIL pause e=%0d got=%h exp=%h", e, got, exp);
            else pass_cnt++;
        end
        bus.pause = 1'b0;
        clean_up();
    endtask

    task automatic test_abort();
        logic [10:0] got, exp;
        launch(8'd5);
        for (int e = 1; e <= 30; e++) begin
            bus.abort = (e == 6);
            cyc();
            if (e < 4)       exp = {3'b100, 8'd5};
            else if (e == 4) exp = {3'b110, 8'd4};
            else if (e < 6)  exp = {3'b100, 8'd4};
            else             exp = 11'h000;
            got = {bus.busy, bus.tick, bus.expired, bus.remaining};
            chk_cnt++;
            if (got !== exp) $display("FAIL abort e=%0d got=%h exp=%h", e, got, exp);
            else pass_cnt++;
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [10:0] got, exp;
        launch(8'd4);
        for (int e = 1; e <= 19; e++) begin
            bus.start    = (e == 10);
            bus.duration = (e == 10) ? 8'd2 : 8'd0;
            cyc();
            if (e < 4)        exp = {3'b100, 8'd4};
            else if (e == 4)  exp = {3'b110, 8'd3};
            else if (e < 8)   exp = {3'b100, 8'd3};
            else if (e == 8)  exp = {3'b110, 8'd2};
            else if (e < 14)  exp = {3'b100, 8'd2};
            else if (e == 14) exp = {3'b110, 8'd1};
            else if (e < 18)  exp = {3'b100, 8'd1};
            else if (e == 18) exp = {AR, 2'b11, (AR ? 8'd2 : 8'd0)};
            else              exp = {AR, 2'b00, (AR ? 8'd2 : 8'd0)};
            got = {bus.busy, bus.tick, bus.expired, bus.remaining};
            chk_cnt++;
            if (got !== exp) $display("FAIL retrigger e=%0d got=%h exp=%h", e, got, exp);
            else pass_cnt++;
        end
        bus.start    = 1'b0;
        bus.duration = '0;
        clean_up();
    endtask

    task automatic test_zero_duration();
        logic [10:0] got, exp;
        launch(8'd0);
        for (int e = 0; e <= 6; e++) begin
            if (e > 0) cyc();
            exp = (e == 0) ? 11'b001_0000_0000 : 11'h000;
            got = {bus.busy, bus.tick, bus.expired, bus.remaining};
            chk_cnt++;
            if (got !== exp) $display("FAIL zero_dur e=%0d got=%h exp=%h", e, got, exp);
            else pass_cnt++;
        end
        // start and abort together while running: abort wins.
        launch(8'd3);
        cyc();
        bus.start    = 1'b1;
        bus.duration = 8'd7;
        bus.abort    = 1'b1;
        cyc();
        bus.start    = 1'b0;
        bus.duration = '0;
        bus.abort    = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            if (e > 0) cyc();
            got = {bus.busy, bus.tick, bus.expired, bus.remaining};
            chk_cnt++;
            if (got !== 11'h000) $display("FAIL start_abort e=%0d got=%h exp=%h", e, got, 11'h000);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_count();
        logic [10:0] got;
        launch(8'd2);
        for (int e = 1; e <= 5; e++) cyc();
        #2;
        rst = 1'b1;
        #1;
        got = {bus.busy, bus.tick, bus.expired, bus.remaining};
        chk_cnt++;
        if (got !== 11'h000) $display("FAIL reset_async got=%h exp=%h", got, 11'h000);
        else pass_cnt++;
        cyc();
        rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            cyc();
            got = {bus.busy, bus.tick, bus.expired, bus.remaining};
            chk_cnt++;
            if (got !== 11'h000) $display("FAIL reset_quiet e=%0d got=%h exp=%h", e, got, 11'h000);
            else pass_cnt++;
        end
    endtask

`ifdef AUTO_RELOAD_EN
    task automatic test_auto_reload();
        logic [10:0] got, exp;
        launch(8'd2);
        for (int e = 1; e <= 30; e++) begin
            bus.abort = (e == 18);
            cyc();
            if (e >= 18)                  exp = 11'h000;
            else if (e == 8 || e == 16)   exp = {3'b111, 8'd2};
            else if (e == 4 || e == 12)   exp = {3'b110, 8'd1};
            else if ((e % 8) >= 4)        exp = {3'b100, 8'd1};
            else                          exp = {3'b100, 8'd2};
            got = {bus.busy, bus.tick, bus.expired, bus.remaining};
            chk_cnt++;
            if (got !== exp) $display("FAIL auto_reload e=%0d got=%h exp=%h", e, got, exp);
            else pass_cnt++;
        end
        bus.abort = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_abort();
        test_back_to_back();
        test_zero_duration();
        test_reset_mid_count();
`ifdef AUTO_RELOAD_EN
        test_auto_reload();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
